psg_filter_mixer: RTL and testbench

PSG_FILTER_MIXER -- requirements
Module: psg_filter_mixer

---
 rtl/psg_mix_pkg.sv | 30 +++
 rtl/psg_chan_iir.sv | 80 ++++++++
 rtl/psg_filter_mixer.sv | 136 +++++++++++++
 tb/tb_psg_filter_mixer.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/psg_mix_pkg.sv
// Shared types and constants for the PSG filter/mixer: FSM states, filter modes,
// low-pass coefficients and the DC-removal shift.
package psg_mix_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_GAIN,
    ST_DCRM,
    ST_LPF,
    ST_ACC,
    ST_DONE
  } state_t;

  typedef enum logic [1:0] {
    FLT_BYPASS,
    FLT_LIGHT,
    FLT_MEDIUM,
    FLT_HEAVY
  } flt_mode_t;

  // Q16 one-pole coefficients; index 0 is never used because bypass copies the input.
  localparam logic [15:0] LPF_COEF [4] = '{16'd0, 16'd14000, 16'd3200, 16'd2640};
  localparam int DC_SHIFT = 10;

  function automatic logic [15:0] lpf_coef(input flt_mode_t m);
    return LPF_COEF[m];
  endfunction

endpackage

// File: rtl/psg_chan_iir.sv
// Shared per-channel DC-removal and one-pole low-pass datapath, stepped by the mixer
// FSM one channel at a time. DC removal exists only when PSG_MIX_DCRM_EN is defined.
module psg_chan_iir
  import psg_mix_pkg::*;
#(
  parameter int NUM_CH = 3,
  parameter int IN_W   = 8
) (
  input  logic                   clk_49m,
  input  logic                   reset,
  input  logic [2:0]             ch,
  input  flt_mode_t              mode,
  input  logic signed [IN_W+8:0] x,
  input  logic                   dcrm_step,
  input  logic                   lpf_step,
  output logic signed [IN_W+9:0] y
);

  localparam int DW = IN_W + 10;
  localparam int PW = DW + 17;

  logic signed [DW-1:0] y_q [NUM_CH];
  logic signed [DW-1:0] y_cur, lpf_in, lpf_diff, lpf_delta;
  logic signed [PW-1:0] coef_s, diff_s, lpf_prod;

  always_comb begin
    y_cur = '0;
    for (int k = 0; k < NUM_CH; k++)
      if (ch == 3'(k)) y_cur = y_q[k];
  end

  assign y = y_cur;

`ifdef PSG_MIX_DCRM_EN
  logic signed [DW-1:0] dc_q [NUM_CH];
  logic signed [DW-1:0] dc_cur, dc_diff, dcrm_q;

  always_comb begin
    dc_cur = '0;
    for (int k = 0; k < NUM_CH; k++)
      if (ch == 3'(k)) dc_cur = dc_q[k];
  end

  // Stage output uses the tracker value from before this frame's update.
  assign dc_diff = DW'(x) - dc_cur;
  assign lpf_in  = dcrm_q;

  always_ff @(posedge clk_49m or negedge reset) begin
    if (!reset) begin
      dcrm_q <= '0;
      for (int k = 0; k < NUM_CH; k++) dc_q[k] <= '0;
    end else if (dcrm_step) begin
      dcrm_q <= dc_diff;
      for (int k = 0; k < NUM_CH; k++)
        if (ch == 3'(k)) dc_q[k] <= dc_cur + (dc_diff >>> DC_SHIFT);
    end
  end
`else
  logic unused_dcrm_step;
  assign unused_dcrm_step = dcrm_step;
  assign lpf_in = DW'(x);
`endif

  assign lpf_diff  = lpf_in - y_cur;
  assign coef_s    = PW'(lpf_coef(mode));
  assign diff_s    = PW'(lpf_diff);
  assign lpf_prod  = coef_s * diff_s;
  assign lpf_delta = DW'(lpf_prod >>> 16);

  // Mode changes never clear y_q: the filter resumes from whatever it last held.
  always_ff @(posedge clk_49m or negedge reset) begin
    if (!reset) begin
      for (int k = 0; k < NUM_CH; k++) y_q[k] <= '0;
    end else if (lpf_step) begin
      for (int k = 0; k < NUM_CH; k++)
        if (ch == 3'(k)) y_q[k] <= (mode == FLT_BYPASS) ? lpf_in : y_cur + lpf_delta;
    end
  end

endmodule

// File: rtl/psg_filter_mixer.sv
// PSG channel mixer: per-frame gain, optional DC removal (PSG_MIX_DCRM_EN), per-channel
// low-pass and a saturating sum, sequenced by one FSM over a shared datapath.
module psg_filter_mixer
  import psg_mix_pkg::*;
#(
  parameter int NUM_CH = 3,
  parameter int IN_W   = 8,
  parameter int OUT_W  = 16,
  parameter int GAIN   = 176
) (
  input  logic                     clk_49m,
  input  logic                     reset,
  input  logic                     cen_smp,
  input  logic [NUM_CH*IN_W-1:0]   ch_in,
  input  logic                     flt_wr,
  input  logic [2:0]               flt_ch,
  input  logic [1:0]               flt_sel,
  output logic signed [OUT_W-1:0]  out,
  output logic                     out_valid,
  output logic                     busy,
  output logic                     overrun
);

  localparam int XW = IN_W + 9;
  localparam int DW = IN_W + 10;
  localparam int AW = DW + 3;
  localparam int SW = (AW > OUT_W) ? AW : OUT_W;
  localparam logic [2:0] LAST_CH = 3'(NUM_CH - 1);
  localparam logic signed [SW-1:0] SAT_MAX = {{(SW-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
  localparam logic signed [SW-1:0] SAT_MIN = ~SAT_MAX;

  state_t                 state;
  logic [2:0]             idx;
  logic [NUM_CH*IN_W-1:0] ch_snap;
  flt_mode_t              flt_q [NUM_CH];
  flt_mode_t              mode_snap [NUM_CH];
  flt_mode_t              mode_cur;
  logic [IN_W-1:0]        sample_q;
  logic [IN_W+7:0]        prod;
  logic signed [XW-1:0]   x_q;
  logic signed [SW-1:0]   acc;
  logic signed [DW-1:0]   y;

  function automatic logic signed [OUT_W-1:0] sat_out(input logic signed [SW-1:0] a);
    if (a > SAT_MAX)      return SAT_MAX[OUT_W-1:0];
    else if (a < SAT_MIN) return SAT_MIN[OUT_W-1:0];
    else                  return a[OUT_W-1:0];
  endfunction

  assign prod = (IN_W+8)'(sample_q) * (IN_W+8)'(GAIN);

  // Out-of-range channel indices match no k, so such writes fall away.
  always_ff @(posedge clk_49m or negedge reset) begin
    if (!reset) begin
      for (int k = 0; k < NUM_CH; k++) flt_q[k] <= FLT_BYPASS;
    end else if (flt_wr) begin
      for (int k = 0; k < NUM_CH; k++)
        if (flt_ch == 3'(k)) flt_q[k] <= flt_mode_t'(flt_sel);
    end
  end

  always_ff @(posedge clk_49m or negedge reset) begin
    if (!reset) begin
      state     <= ST_IDLE;
      idx       <= '0;
      ch_snap   <= '0;
      sample_q  <= '0;
      x_q       <= '0;
      acc       <= '0;
      mode_cur  <= FLT_BYPASS;
      out       <= '0;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      overrun   <= 1'b0;
      for (int k = 0; k < NUM_CH; k++) mode_snap[k] <= FLT_BYPASS;
    end else begin
      out_valid <= 1'b0;
      if (cen_smp && state != ST_IDLE) overrun <= 1'b1;
      case (state)
        ST_IDLE: if (cen_smp) begin
          ch_snap <= ch_in;
          for (int k = 0; k < NUM_CH; k++) mode_snap[k] <= flt_q[k];
          acc   <= '0;
          idx   <= '0;
          busy  <= 1'b1;
          state <= ST_LOAD;
        end
        ST_LOAD: begin
          for (int k = 0; k < NUM_CH; k++)
            if (idx == 3'(k)) begin
              sample_q <= ch_snap[k*IN_W +: IN_W];
              mode_cur <= mode_snap[k];
            end
          state <= ST_GAIN;
        end
        ST_GAIN: begin
          x_q <= signed'({1'b0, prod});
`ifdef PSG_MIX_DCRM_EN
          state <= ST_DCRM;
`else
          state <= ST_LPF;
`endif
        end
        ST_DCRM: state <= ST_LPF;
        ST_LPF:  state <= ST_ACC;
        ST_ACC: begin
          acc <= acc + SW'(y);
          if (idx == LAST_CH) state <= ST_DONE;
          else begin
            idx   <= idx + 3'd1;
            state <= ST_LOAD;
          end
        end
        ST_DONE: begin
          out       <= sat_out(acc);
          out_valid <= 1'b1;
          busy      <= 1'b0;
          state     <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  psg_chan_iir #(.NUM_CH(NUM_CH), .IN_W(IN_W)) u_iir (
    .clk_49m   (clk_49m),
    .reset     (reset),
    .ch        (idx),
    .mode      (mode_cur),
    .x         (x_q),
    .dcrm_step (state == ST_DCRM),
    .lpf_step  (state == ST_LPF),
    .y         (y)
  );

endmodule

// File: tb/tb_psg_filter_mixer.sv
// Bench for psg_filter_mixer: vector table plus hand sequences for overrun, reset abort,
// filter-write timing and filter convergence; out_valid results checked via a queue.
module tb_psg_filter_mixer;

  localparam int NUM_CH = 3;
  localparam int IN_W   = 8;
  localparam int OUT_W  = 16;
`ifdef PSG_MIX_DCRM_EN
  localparam int LAT   = 5*NUM_CH + 2;
  localparam int EXP_B = 13836;
`else
  localparam int LAT   = 4*NUM_CH + 2;
  localparam int EXP_B = 13840;
`endif

  logic                    clk_49m = 1'b0;
  logic                    reset   = 1'b0;
  logic                    cen_smp = 1'b0;
  logic [NUM_CH*IN_W-1:0]  ch_in   = '0;
  logic                    flt_wr  = 1'b0;
  logic [2:0]              flt_ch  = '0;
  logic [1:0]              flt_sel = '0;
  logic signed [OUT_W-1:0] out;
  logic                    out_valid, busy, overrun;

  int checks = 0, errors = 0, cyc = 0, valid_cnt = 0, last_out = 0;
  logic [OUT_W-1:0] exp_q[$];
  int               cyc_q[$];
  string            name_q[$];

  typedef struct {
    logic [7:0] c0, c1, c2;
    logic [1:0] m0, m1, m2;
    int         exp_out;
  } vec_t;
  vec_t vecs [11];

  psg_filter_mixer #(.NUM_CH(NUM_CH), .IN_W(IN_W), .OUT_W(OUT_W), .GAIN(176)) dut (
    .clk_49m   (clk_49m),
    .reset     (reset),
    .cen_smp   (cen_smp),
    .ch_in     (ch_in),
    .flt_wr    (flt_wr),
    .flt_ch    (flt_ch),
    .flt_sel   (flt_sel),
    .out       (out),
    .out_valid (out_valid),
    .busy      (busy),
    .overrun   (overrun)
  );

  always #10 clk_49m = ~clk_49m;
  always @(posedge clk_49m) cyc++;

  task automatic chk(input string nm, input logic signed [31:0] act, input logic signed [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // Scoreboard: every out_valid pops one expected record.
  always @(negedge clk_49m) begin
    if (reset && out_valid) begin
      valid_cnt++;
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_valid: got pulse with out %0d, expected none", out);
      end else begin
        automatic logic [OUT_W-1:0] e = exp_q.pop_front();
        automatic int    c = cyc_q.pop_front();
        automatic string n = name_q.pop_front();
        chk(n, out, $signed(e));
        chk({n, "_lat"}, cyc - c, LAT);
        last_out = out;
      end
    end
  end

  task automatic flush();
    exp_q.delete();
    cyc_q.delete();
    name_q.delete();
  endtask

  task automatic do_reset();
    reset = 1'b0; cen_smp = 1'b0; flt_wr = 1'b0;
    flush();
    repeat (2) @(posedge clk_49m);
    #1 reset = 1'b1;
  endtask

  task automatic write_flt(input logic [2:0] ch, input logic [1:0] sel);
    @(posedge clk_49m); #1;
    flt_wr = 1'b1; flt_ch = ch; flt_sel = sel;
    @(posedge clk_49m); #1;
    flt_wr = 1'b0;
  endtask

  task automatic start_frame(input logic [23:0] ch, input int exp, input string nm,
                             input logic wr, input logic [2:0] wch, input logic [1:0] wsel);
    @(posedge clk_49m); #1;
    ch_in = ch; cen_smp = 1'b1;
    flt_wr = wr; flt_ch = wch; flt_sel = wsel;
    exp_q.push_back(OUT_W'(exp));
    cyc_q.push_back(cyc);
    name_q.push_back(nm);
    @(posedge clk_49m); #1;
    cen_smp = 1'b0; flt_wr = 1'b0;
  endtask

  task automatic wait_done(input string nm);
    int t;
    t = 0;
    while (exp_q.size() != 0 && t < 4*LAT) begin
      @(posedge clk_49m);
      t++;
    end
    if (exp_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL %s_timeout: got no out_valid, expected one within %0d cycles", nm, 4*LAT);
      flush();
    end
    @(negedge clk_49m);
  endtask

  initial begin
    #1_500_000;
    $display("FAIL watchdog: got no finish, expected end before time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int y, prev, v0, dc, diff;
    vecs[0]  = '{8'd100, 8'd0,   8'd0,   2'd0, 2'd0, 2'd0, 17600};
    vecs[1]  = '{8'd255, 8'd255, 8'd255, 2'd0, 2'd0, 2'd0, 32767};
    vecs[2]  = '{8'd0,   8'd0,   8'd0,   2'd0, 2'd0, 2'd0, 0};
    vecs[3]  = '{8'd1,   8'd2,   8'd3,   2'd0, 2'd0, 2'd0, 1056};
    vecs[4]  = '{8'd186, 8'd0,   8'd0,   2'd0, 2'd0, 2'd0, 32736};
    vecs[5]  = '{8'd187, 8'd0,   8'd0,   2'd0, 2'd0, 2'd0, 32767};
    vecs[6]  = '{8'd100, 8'd0,   8'd0,   2'd1, 2'd0, 2'd0, 3759};
    vecs[7]  = '{8'd100, 8'd0,   8'd0,   2'd2, 2'd0, 2'd0, 859};
    vecs[8]  = '{8'd100, 8'd0,   8'd100, 2'd0, 2'd0, 2'd3, 18308};
    vecs[9]  = '{8'd100, 8'd50,  8'd0,   2'd0, 2'd1, 2'd0, 19479};
    vecs[10] = '{8'd0,   8'd0,   8'd255, 2'd0, 2'd0, 2'd0, 32767};

    repeat (3) @(posedge clk_49m);
    @(negedge clk_49m);
    chk("rst_out", out, 0);
    chk("rst_valid", out_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_overrun", overrun, 0);

    for (int i = 0; i < 11; i++) begin
      do_reset();
      write_flt(3'd0, vecs[i].m0);
      write_flt(3'd1, vecs[i].m1);
      write_flt(3'd2, vecs[i].m2);
      start_frame({vecs[i].c2, vecs[i].c1, vecs[i].c0}, vecs[i].exp_out,
                  $sformatf("vec%0d", i), 1'b0, 3'd0, 2'd0);
      chk($sformatf("vec%0d_busy", i), busy, 1);
      wait_done($sformatf("vec%0d", i));
    end

    // Write to a non-existent channel must leave all modes at bypass.
    do_reset();
    write_flt(3'd5, 2'd1);
    start_frame({8'd10, 8'd10, 8'd10}, 5280, "bad_ch", 1'b0, 3'd0, 2'd0);
    wait_done("bad_ch");
    chk("no_overrun", overrun, 0);

    // Same-cycle write: frame A sees bypass, frame B sees light mode starting from y=17600.
    do_reset();
    start_frame({8'd0, 8'd0, 8'd100}, 17600, "same_cyc_a", 1'b1, 3'd0, 2'd1);
    wait_done("same_cyc_a");
    start_frame({8'd0, 8'd0, 8'd0}, EXP_B, "same_cyc_b", 1'b0, 3'd0, 2'd0);
    wait_done("same_cyc_b");

    // Write while busy only affects the following frame.
    do_reset();
    start_frame({8'd0, 8'd0, 8'd100}, 17600, "mid_wr_a", 1'b0, 3'd0, 2'd0);
    write_flt(3'd0, 2'd1);
    wait_done("mid_wr_a");
    start_frame({8'd0, 8'd0, 8'd0}, EXP_B, "mid_wr_b", 1'b0, 3'd0, 2'd0);
    wait_done("mid_wr_b");

    // Overrun: second strobe three cycles into the frame is dropped.
    do_reset();
    v0 = valid_cnt;
    start_frame({8'd10, 8'd10, 8'd10}, 5280, "ovr", 1'b0, 3'd0, 2'd0);
    @(posedge clk_49m);
    @(posedge clk_49m); #1;
    cen_smp = 1'b1;
    @(posedge clk_49m); #1;
    cen_smp = 1'b0;
    wait_done("ovr");
    repeat (3*LAT) @(posedge clk_49m);
    @(negedge clk_49m);
    chk("ovr_flag", overrun, 1);
    chk("ovr_one_valid", valid_cnt - v0, 1);

    // Reset four cycles into a frame aborts it.
    do_reset();
    start_frame({8'd0, 8'd0, 8'd100}, 17600, "pre_abort", 1'b0, 3'd0, 2'd0);
    wait_done("pre_abort");
    v0 = valid_cnt;
    start_frame({8'd0, 8'd0, 8'd50}, 0, "abort", 1'b0, 3'd0, 2'd0);
    repeat (3) @(posedge clk_49m);
    #1 reset = 1'b0;
    flush();
    @(negedge clk_49m);
    chk("abort_out", out, 0);
    chk("abort_busy", busy, 0);
    repeat (2) @(posedge clk_49m);
    #1 reset = 1'b1;
    repeat (3*LAT) @(posedge clk_49m);
    @(negedge clk_49m);
    chk("abort_no_valid", valid_cnt - v0, 0);
    start_frame({8'd0, 8'd0, 8'd100}, 17600, "post_abort", 1'b0, 3'd0, 2'd0);
    wait_done("post_abort");

`ifndef PSG_MIX_DCRM_EN
    // Light filter rising toward 17600 over successive frames.
    do_reset();
    write_flt(3'd0, 2'd1);
    y = 0;
    prev = -1;
    for (int f = 0; f < 8; f++) begin
      y = y + (14000 * (17600 - y)) / 65536;
      start_frame({8'd0, 8'd0, 8'd100}, y, $sformatf("rise%0d", f), 1'b0, 3'd0, 2'd0);
      wait_done($sformatf("rise%0d", f));
      chk($sformatf("rise%0d_mono", f), (last_out > prev && last_out <= 17600), 1);
      prev = last_out;
    end
`else
    // DC removal decaying a constant input toward zero.
    do_reset();
    dc = 0;
    prev = 17601;
    for (int f = 0; f < 200; f++) begin
      diff = 17600 - dc;
      start_frame({8'd0, 8'd0, 8'd100}, diff, $sformatf("decay%0d", f), 1'b0, 3'd0, 2'd0);
      wait_done($sformatf("decay%0d", f));
      dc = dc + (diff >>> 10);
      if (f % 50 == 0) chk($sformatf("decay%0d_mono", f), (last_out < prev), 1);
      prev = last_out;
    end
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
